// File: rtl/bridge_deadtime.sv
// Four-leg gate-drive conditioner: break-before-make dead time, shoot-through refusal and kill.
// Optional sticky fault lock enabled by defining BRIDGE_DEADTIME_FAULT_LATCH_EN.
module bridge_deadtime #(
    parameter int DEAD_CYCLES = 50,
    parameter int CNT_WIDTH   = $clog2(DEAD_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:1] req_top,
    input  logic [4:1] req_bot,
    input  logic       kill,
    input  logic       fault_clr,
    output logic [4:1] gate_top,
    output logic [4:1] gate_bot,
    output logic [4:1] fault_st,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEAD = 2'd1,
        S_TOP  = 2'd2,
        S_BOT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_TOP  = 2'd1,
        R_BOT  = 2'd2
    } eff_t;

    localparam logic [CNT_WIDTH-1:0] DEAD_LOAD = CNT_WIDTH'(DEAD_CYCLES - 1);

    state_t               state_q [4:1];
    state_t               state_d [4:1];
    logic [CNT_WIDTH-1:0] cnt_q   [4:1];
    logic [CNT_WIDTH-1:0] cnt_d   [4:1];
    eff_t                 eff     [4:1];
    logic [4:1]           shoot;
    logic [4:1]           lock;
    logic [4:1]           fault_d, fault_q;
    logic [4:1]           gate_top_d, gate_top_q;
    logic [4:1]           gate_bot_d, gate_bot_q;
    logic                 busy_d, busy_q;

`ifndef BRIDGE_DEADTIME_FAULT_LATCH_EN
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
`endif

    always_comb begin
        shoot   = req_top & req_bot;
`ifdef BRIDGE_DEADTIME_FAULT_LATCH_EN
        // A new shoot-through request beats a simultaneous clear.
        fault_d = shoot | (fault_q & ~({4{fault_clr}} & ~shoot));
        lock    = fault_q;
`else
        fault_d = shoot;
        lock    = 4'b0000;
`endif
    end

    always_comb begin
        busy_d = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            eff[i]        = R_NONE;
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            if (!kill && !shoot[i] && !lock[i]) begin
                if (req_top[i])      eff[i] = R_TOP;
                else if (req_bot[i]) eff[i] = R_BOT;
            end

            case (state_q[i])
                S_IDLE: begin
                    if (eff[i] == R_TOP)      state_d[i] = S_TOP;
                    else if (eff[i] == R_BOT) state_d[i] = S_BOT;
                end
                S_TOP: begin
                    if (eff[i] != R_TOP) begin
                        state_d[i] = S_DEAD;
                        cnt_d[i]   = DEAD_LOAD;
                    end
                end
                S_BOT: begin
                    if (eff[i] != R_BOT) begin
                        state_d[i] = S_DEAD;
                        cnt_d[i]   = DEAD_LOAD;
                    end
                end
                default: begin
                    // No shortcut: even a same-side re-request waits out the full count.
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end else if (eff[i] == R_TOP) begin
                        state_d[i] = S_TOP;
                    end else if (eff[i] == R_BOT) begin
                        state_d[i] = S_BOT;
                    end else begin
                        state_d[i] = S_IDLE;
                    end
                end
            endcase

            gate_top_d[i] = (state_d[i] == S_TOP);
            gate_bot_d[i] = (state_d[i] == S_BOT);
            busy_d        = busy_d | (state_d[i] == S_DEAD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 4; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            fault_q    <= '0;
            gate_top_q <= '0;
            gate_bot_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            for (int i = 1; i <= 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            fault_q    <= fault_d;
            gate_top_q <= gate_top_d;
            gate_bot_q <= gate_bot_d;
            busy_q     <= busy_d;
        end
    end

    assign gate_top = gate_top_q;
    assign gate_bot = gate_bot_q;
    assign fault_st = fault_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bridge_deadtime.sv
// Scoreboarded directed bench for bridge_deadtime with DEAD_CYCLES=4.
module tb_bridge_deadtime;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:1] req_top = '0;
    logic [4:1] req_bot = '0;
    logic       kill = 1'b0;
    logic       fault_clr = 1'b0;
    logic [4:1] gate_top, gate_bot, fault_st;
    logic       busy;

    typedef struct packed {
        logic [3:0] gt;
        logic [3:0] gb;
        logic [3:0] f;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bridge_deadtime #(.DEAD_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .req_top(req_top), .req_bot(req_bot),
        .kill(kill), .fault_clr(fault_clr),
        .gate_top(gate_top), .gate_bot(gate_bot), .fault_st(fault_st), .busy(busy)
    );

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [3:0] t, input logic [3:0] b,
                        input logic k, input logic c,
                        input logic [3:0] et, input logic [3:0] eb,
                        input logic [3:0] ef, input logic ebusy);
        exp_t e;
        @(negedge clk);
        rst = r; req_top = t; req_bot = b; kill = k; fault_clr = c;
        e.gt = et; e.gb = eb; e.f = ef; e.b = ebusy;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("gate_top", gate_top, e.gt);
                check("gate_bot", gate_bot, e.gb);
                check("fault_st", fault_st, e.f);
                check("busy", {3'b000, busy}, {3'b000, e.b});
                check("overlap", gate_top & gate_bot, 4'b0000);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: timeout reached, required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset held with a top request pending
        step(1, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(1, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0);
        // polarity swap top -> bot
        step(0, 4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        for (int i = 0; i < DC - 1; i++)
            step(0, 4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        step(0, 4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);
        // back to top
        for (int i = 0; i < DC; i++)
            step(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        step(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0);
        // same-side re-request after one idle cycle
        step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        for (int i = 0; i < DC - 1; i++)
            step(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        step(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0);
        // kill with legs 1 and 2 on
        step(0, 4'b0001, 4'b0010, 0, 0, 4'b0001, 4'b0010, 4'b0000, 0);
        for (int i = 0; i < DC; i++)
            step(0, 4'b0001, 4'b0010, 1, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        for (int i = 0; i < 10 - DC; i++)
            step(0, 4'b0001, 4'b0010, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0010, 0, 0, 4'b0001, 4'b0010, 4'b0000, 0);
        // release both legs
        for (int i = 0; i < DC; i++)
            step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // shoot-through on leg 3, leg 1 unaffected
        step(0, 4'b0101, 4'b0100, 0, 0, 4'b0001, 4'b0000, 4'b0100, 0);
        step(0, 4'b0101, 4'b0100, 0, 0, 4'b0001, 4'b0000, 4'b0100, 0);
`ifdef BRIDGE_DEADTIME_FAULT_LATCH_EN
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0100, 0);
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0100, 0);
        step(0, 4'b0101, 4'b0000, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0);
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0101, 4'b0000, 4'b0000, 0);
`else
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0101, 4'b0000, 4'b0000, 0);
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0101, 4'b0000, 4'b0000, 0);
        step(0, 4'b0101, 4'b0000, 0, 1, 4'b0101, 4'b0000, 4'b0000, 0);
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0101, 4'b0000, 4'b0000, 0);
`endif
        // shoot-through with a simultaneous clear: the set wins, leg 3 drops into dead time
        step(0, 4'b0101, 4'b0100, 0, 1, 4'b0001, 4'b0000, 4'b0100, 1);
        for (int i = 0; i < DC - 1; i++)
            step(0, 4'b0101, 4'b0100, 0, 0, 4'b0001, 4'b0000, 4'b0100, 1);
        step(0, 4'b0101, 4'b0100, 0, 0, 4'b0001, 4'b0000, 4'b0100, 0);
`ifdef BRIDGE_DEADTIME_FAULT_LATCH_EN
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0100, 0);
`else
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0101, 4'b0000, 4'b0000, 0);
`endif
        // reset mid-operation, then immediate turn-on
        step(1, 4'b0101, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b0101, 4'b0000, 0, 0, 4'b0101, 4'b0000, 4'b0000, 0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
